ec_correct_pipe_param: RTL
==========================

EC_CORRECT_PIPE_PARAM -- requirements
Module: ec_correct_pipe_param

Interface
REQ-001 SHALL have parameter NUM_DIG, default 10, residue digit count (legal 3..16).
REQ-002 SHALL have parameter DIG_W, default 18, bits per residue digit.
REQ-003 SHALL have parameter SKP_LAT, default 81, cycles from dig_in to aligned skip results (legal 1..128).
REQ-004 SHALL have parameter CNT_W, default 16, width of each error counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-007 SHALL have port reset, input, 1 bit: async active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: dig_in holds a new word.
REQ-009 SHALL have port dig_in, input, NUM_DIG*DIG_W bits: digit k at bits [k*DIG_W +: DIG_W].
REQ-010 SHALL have port skp_ok, input, NUM_DIG bits: bit k=1 means the skip-k projection is in legal range (sign A == sign B == positive/negative legal code).
REQ-011 SHALL have port cor_dig, input, NUM_DIG*DIG_W bits: recombined digit k from skip-k engine.
REQ-012 SHALL have port bypass, input, 1 bit: 1 forces passthrough with no correction and no error flags.
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous clear of all counters.
REQ-014 SHALL have port out_valid, output, 1 bit: dig_out and flags are valid.
REQ-015 SHALL have port dig_out, output, NUM_DIG*DIG_W bits: corrected word.
REQ-016 SHALL have ports cor_error, non_cor_error and mal_error, output, 1 bit each: per-word status.
REQ-017 SHALL have port err_idx, output, $clog2(NUM_DIG) bits: index of the corrected digit.
REQ-018 SHALL have ports cor_cnt, noncor_cnt and mal_cnt, output, CNT_W bits each: saturating event counters.

Function
REQ-019 SHALL delay dig_in and in_valid by exactly SKP_LAT cycles through a shift-register line with no gaps; words arrive back-to-back, and there is no backpressure.
REQ-020 SHALL sample skp_ok and cor_dig on the cycle the delayed in_valid is 1; the upstream skip engines guarantee this alignment.
REQ-021 SHALL classify each word by n = popcount(skp_ok): n == NUM_DIG means clean; n == 1 means correctable at j, where j is the set bit; n == 0 means non-correctable; 2 <= n <= NUM_DIG-1 means malformed.
REQ-022 SHALL, for a correctable word, output delayed digit j replaced by cor_dig[j], with all other digits unchanged.
REQ-023 SHALL, for clean, non-correctable or malformed words, output the delayed dig_in unchanged.
REQ-024 SHALL register all outputs, giving a total latency of SKP_LAT+1 cycles from in_valid to out_valid.
REQ-025 SHALL drive flags one-hot or all zero: cor_error is 1 only for correctable words, non_cor_error only for n == 0, and mal_error only for malformed words.
REQ-026 SHALL drive err_idx = j when cor_error is 1, and 0 otherwise.
REQ-027 SHALL hold dig_out, flags and err_idx at their last values when out_valid is 0; flags are meaningful only when out_valid is 1.
REQ-028 SHALL, when bypass is sampled 1 with the delayed word, pass that word unchanged with all flags 0 and no counter increments; bypass is sampled at the output stage, not at input.
REQ-029 SHALL increment the counter for each flagged word, saturating at 2^CNT_W-1 with no wrap.
REQ-030 SHALL give cnt_clr priority over a simultaneous increment, so counters read 0 on the next cycle.

Reset
REQ-031 SHALL, on reset assertion, immediately clear the delay-line valid bits, out_valid, all flags, err_idx, dig_out and all counters to 0.
REQ-032 SHALL discard every word in flight when reset asserts mid-stream; no out_valid occurs for them after release.
REQ-033 SHALL NOT require the delay-line data bits to be reset; only the valid bits are reset.

Verification (NUM_DIG=10, DIG_W=18, SKP_LAT=4)
REQ-034 SHALL cover: in_valid pulse with dig_in digits = k+1 and skp_ok = 0x3FF at cycle 4 -> out_valid at cycle 5, dig_out equal to the input, all flags 0.
REQ-035 SHALL cover: skp_ok = 0x008 with cor_dig[3] = 0x00ABC -> dig_out digit 3 = 0x00ABC, others unchanged, cor_error = 1, err_idx = 3, cor_cnt = 1.
REQ-036 SHALL cover: skp_ok = 0x000 -> non_cor_error = 1, data unchanged; skp_ok = 0x011 -> mal_error = 1, mal_cnt increments.
REQ-037 SHALL cover: 20 back-to-back words with alternating correctable and clean words -> 20 consecutive out_valid, cor_cnt = 10, order preserved.
REQ-038 SHALL cover: CNT_W=2 with 5 correctable words -> cor_cnt saturates at 3; cnt_clr together with a sixth correctable word -> 0.
REQ-039 SHALL cover: reset asserted 2 cycles after in_valid -> all outputs 0 at once, and no out_valid occurs for that word after release.

Source files
------------

// File: rtl/ec_correct_pipe_param.sv
// ec_correct_pipe_param: delays residue words to the skip results, corrects single-digit errors and counts error events
module ec_correct_pipe_param #(
  parameter int NUM_DIG = 10,
  parameter int DIG_W   = 18,
  parameter int SKP_LAT = 81,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [NUM_DIG*DIG_W-1:0]     dig_in,
  input  logic [NUM_DIG-1:0]           skp_ok,
  input  logic [NUM_DIG*DIG_W-1:0]     cor_dig,
  input  logic                         bypass,
  input  logic                         cnt_clr,
  output logic                         out_valid,
  output logic [NUM_DIG*DIG_W-1:0]     dig_out,
  output logic                         cor_error,
  output logic                         non_cor_error,
  output logic                         mal_error,
  output logic [$clog2(NUM_DIG)-1:0]   err_idx,
  output logic [CNT_W-1:0]             cor_cnt,
  output logic [CNT_W-1:0]             noncor_cnt,
  output logic [CNT_W-1:0]             mal_cnt
);
  localparam int W  = NUM_DIG*DIG_W;
  localparam int IW = $clog2(NUM_DIG);
  localparam int PW = $clog2(NUM_DIG+1);
  logic [W-1:0]       dly_d [SKP_LAT];
  logic [SKP_LAT-1:0] dly_v;
  logic [PW-1:0]      n;
  logic [IW-1:0]      j;
  logic [W-1:0]       fix;
  logic               hit, f_cor, f_nc, f_mal;
  assign hit = dly_v[SKP_LAT-1];
  always_ff @(posedge clk) begin
    dly_d[0] <= dig_in;
    for (int i = 1; i < SKP_LAT; i++) dly_d[i] <= dly_d[i-1];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dly_v <= '0;
    else begin
      dly_v[0] <= in_valid;
      for (int i = 1; i < SKP_LAT; i++) dly_v[i] <= dly_v[i-1];
    end
  end
  always_comb begin
    n   = '0;
    j   = '0;
    fix = dly_d[SKP_LAT-1];
    for (int k = 0; k < NUM_DIG; k++) begin
      n = n + PW'(skp_ok[k]);
      if (skp_ok[k]) j = IW'(k);
    end
    f_cor = !bypass && n == PW'(1);
    f_nc  = !bypass && n == '0;
    f_mal = !bypass && !f_cor && !f_nc && n != PW'(NUM_DIG);
    if (f_cor) fix[j*DIG_W +: DIG_W] = cor_dig[j*DIG_W +: DIG_W];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      dig_out       <= '0;
      cor_error     <= 1'b0;
      non_cor_error <= 1'b0;
      mal_error     <= 1'b0;
      err_idx       <= '0;
    end else begin
      out_valid <= hit;
      if (hit) begin
        dig_out       <= fix;
        cor_error     <= f_cor;
        non_cor_error <= f_nc;
        mal_error     <= f_mal;
        err_idx       <= f_cor ? j : '0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset || cnt_clr) begin
      cor_cnt    <= '0;
      noncor_cnt <= '0;
      mal_cnt    <= '0;
    end else begin
      if (hit && f_cor && ~&cor_cnt)    cor_cnt    <= cor_cnt + CNT_W'(1);
      if (hit && f_nc  && ~&noncor_cnt) noncor_cnt <= noncor_cnt + CNT_W'(1);
      if (hit && f_mal && ~&mal_cnt)    mal_cnt    <= mal_cnt + CNT_W'(1);
    end
  end
endmodule
